// File: rtl/ext_pattern_fill.sv
// Counted stream generator between streamer read and write ports:
// pass-through, byte fill, 32-bit word fill or incrementing 32-bit sequence.
module ext_pattern_fill #(
   parameter int unsigned DataWidth  = 512,
   parameter int unsigned UserCsrNum = 3,
   parameter int unsigned CntWidth   = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   output logic                 ext_data_i_ready,
   input  logic                 ext_data_i_valid,
   input  logic [DataWidth-1:0] ext_data_i_bits,
   input  logic                 ext_data_o_ready,
   output logic                 ext_data_o_valid,
   output logic [DataWidth-1:0] ext_data_o_bits,
   input  logic [31:0]          ext_csr_i_0,
   input  logic [31:0]          ext_csr_i_1,
   input  logic [31:0]          ext_csr_i_2,
   input  logic                 ext_start_i,
   output logic                 ext_busy_o
);

   localparam int unsigned Lanes = DataWidth / 32;
   localparam int unsigned Bytes = DataWidth / 8;

   // Parameter sanity checks at elaboration
   if (UserCsrNum != 3) begin : g_bad_csr_num
      $error("ext_pattern_fill: UserCsrNum must be 3");
   end
   if ((DataWidth < 32) || ((DataWidth % 32) != 0)) begin : g_bad_width
      $error("ext_pattern_fill: DataWidth must be a multiple of 32 and >= 32");
   end

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [CntWidth-1:0] remaining_q, remaining_d;
   logic [1:0]          mode_q, mode_d;
   logic [7:0]          fill_q, fill_d;
   logic [31:0]         pattern_q, pattern_d;
   logic [31:0]         lane_base_q, lane_base_d;
   logic                run;
   logic                xfer;

   // CSR bits that carry no meaning for this block
   logic unused_csr;
   assign unused_csr = ^{ext_csr_i_0[31:16], ext_csr_i_0[7:2], ext_csr_i_2};

   // State and latched run parameters; synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         mode_q      <= '0;
         fill_q      <= '0;
         pattern_q   <= '0;
         lane_base_q <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         mode_q      <= mode_d;
         fill_q      <= fill_d;
         pattern_q   <= pattern_d;
         lane_base_q <= lane_base_d;
      end
   end

   // Next-state, run bookkeeping, handshake and generated beat
   always_comb begin
      state_d          = state_q;
      remaining_d      = remaining_q;
      mode_d           = mode_q;
      fill_d           = fill_q;
      pattern_d        = pattern_q;
      lane_base_d      = lane_base_q;
      run              = (state_q == ST_RUN);
      xfer             = run && ext_data_i_valid && ext_data_o_ready;
      ext_busy_o       = run;
      ext_data_o_valid = run && ext_data_i_valid;
      ext_data_i_ready = run && ext_data_o_ready;
      ext_data_o_bits  = '0;

      unique case (state_q)
         ST_IDLE: begin
            // A zero-length request is dropped without ever going busy
            if (ext_start_i && (ext_csr_i_2[CntWidth-1:0] != '0)) begin
               mode_d      = ext_csr_i_0[1:0];
               fill_d      = ext_csr_i_0[15:8];
               pattern_d   = ext_csr_i_1;
               lane_base_d = ext_csr_i_1;
               remaining_d = ext_csr_i_2[CntWidth-1:0];
               state_d     = ST_RUN;
            end
         end
         ST_RUN: begin
            // Exit on the last beat, so the counter never wraps below zero
            if (xfer) begin
               remaining_d = remaining_q - CntWidth'(1);
               lane_base_d = lane_base_q + 32'(Lanes);
               if (remaining_q == CntWidth'(1)) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (run) begin
         unique case (mode_q)
            2'd0: ext_data_o_bits = ext_data_i_bits;
            2'd1: begin
               for (int unsigned b = 0; b < Bytes; b++) begin
                  ext_data_o_bits[b*8 +: 8] = fill_q;
               end
            end
            2'd2: begin
               for (int unsigned k = 0; k < Lanes; k++) begin
                  ext_data_o_bits[k*32 +: 32] = pattern_q;
               end
            end
            default: begin
               for (int unsigned k = 0; k < Lanes; k++) begin
                  ext_data_o_bits[k*32 +: 32] = lane_base_q + 32'(k);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ext_pattern_fill.sv
// Self-checking bench for ext_pattern_fill: directed scenarios plus
// randomized runs against a beat-index based reference model.
module tb_ext_pattern_fill;

   localparam int unsigned DW    = 512;
   localparam int unsigned LANES = DW / 32;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          ext_data_i_ready;
   logic          ext_data_i_valid = 1'b0;
   logic [DW-1:0] ext_data_i_bits = '0;
   logic          ext_data_o_ready = 1'b0;
   logic          ext_data_o_valid;
   logic [DW-1:0] ext_data_o_bits;
   logic [31:0]   ext_csr_i_0 = '0;
   logic [31:0]   ext_csr_i_1 = '0;
   logic [31:0]   ext_csr_i_2 = '0;
   logic          ext_start_i = 1'b0;
   logic          ext_busy_o;

   always #5 clk_i = ~clk_i;

   ext_pattern_fill #(
      .DataWidth (DW),
      .UserCsrNum(3),
      .CntWidth  (32)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .ext_data_i_ready(ext_data_i_ready),
      .ext_data_i_valid(ext_data_i_valid),
      .ext_data_i_bits (ext_data_i_bits),
      .ext_data_o_ready(ext_data_o_ready),
      .ext_data_o_valid(ext_data_o_valid),
      .ext_data_o_bits (ext_data_o_bits),
      .ext_csr_i_0     (ext_csr_i_0),
      .ext_csr_i_1     (ext_csr_i_1),
      .ext_csr_i_2     (ext_csr_i_2),
      .ext_start_i     (ext_start_i),
      .ext_busy_o      (ext_busy_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: run flag, latched settings, beats left, beats done
   bit          m_run  = 1'b0;
   logic [1:0]  m_mode = '0;
   logic [7:0]  m_byte = '0;
   logic [31:0] m_pat  = '0;
   logic [31:0] m_left = '0;
   int unsigned m_idx  = 0;

   // DUT observations
   logic [DW-1:0] last_bits;
   int            dut_xfers   = 0;
   int            busy_cycles = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_beat();
      logic [DW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Expected beat: mode 3 lane k of beat j is seed + j*LANES + k
   function automatic logic [DW-1:0] exp_bits(input logic [DW-1:0] ib);
      logic [DW-1:0] r;
      r = '0;
      if (m_run) begin
         case (m_mode)
            2'd0: r = ib;
            2'd1: for (int b = 0; b < DW/8; b++) r[b*8 +: 8] = m_byte;
            2'd2: for (int k = 0; k < LANES; k++) r[k*32 +: 32] = m_pat;
            default: for (int k = 0; k < LANES; k++) r[k*32 +: 32] = m_pat + 32'(m_idx*LANES + k);
         endcase
      end
      return r;
   endfunction

   // One clock: drive at negedge, check outputs, then advance model at posedge
   task automatic step(input logic start, input logic [31:0] c0, input logic [31:0] c1,
                       input logic [31:0] c2, input logic iv, input logic [DW-1:0] ib,
                       input logic ordy, input string tag);
      bit xfer;
      @(negedge clk_i);
      ext_start_i = start; ext_csr_i_0 = c0; ext_csr_i_1 = c1; ext_csr_i_2 = c2;
      ext_data_i_valid = iv; ext_data_i_bits = ib; ext_data_o_ready = ordy;
      #1;
      check({tag, "/busy"},  DW'(ext_busy_o),       DW'(m_run));
      check({tag, "/valid"}, DW'(ext_data_o_valid), DW'(m_run && iv));
      check({tag, "/ready"}, DW'(ext_data_i_ready), DW'(m_run && ordy));
      check({tag, "/bits"},  ext_data_o_bits,       exp_bits(ib));
      last_bits = ext_data_o_bits;
      if (ext_data_o_valid && ordy) dut_xfers++;
      if (ext_busy_o) busy_cycles++;
      xfer = m_run && iv && ordy;
      @(posedge clk_i);
      if (m_run) begin
         if (xfer) begin
            m_idx++;
            if (m_left == 32'd1) m_run = 1'b0;
            m_left = m_left - 32'd1;
         end
      end else if (start && (c2 != 32'd0)) begin
         m_run = 1'b1; m_mode = c0[1:0]; m_byte = c0[15:8];
         m_pat = c1; m_left = c2; m_idx = 0;
      end
   endtask

   task automatic reset_dut();
      @(negedge clk_i);
      rst_ni = 1'b0; ext_start_i = 1'b0;
      ext_data_i_valid = 1'b1; ext_data_o_ready = 1'b1; ext_data_i_bits = rand_beat();
      @(posedge clk_i);
      m_run = 1'b0; m_mode = '0; m_byte = '0; m_pat = '0; m_left = '0; m_idx = 0;
      #1;
      check("rst/busy",  DW'(ext_busy_o),       '0);
      check("rst/valid", DW'(ext_data_o_valid), '0);
      check("rst/ready", DW'(ext_data_i_ready), '0);
      check("rst/bits",  ext_data_o_bits,       '0);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] b1, b2, b3;
      b1 = '0; b2 = '0; b3 = '0;
      for (int i = 0; i < LANES; i++) begin
         b1[i*32 +: 32] = 32'h1111_1111;
         b2[i*32 +: 32] = 32'h2222_2222;
         b3[i*32 +: 32] = 32'h3333_3333;
      end
      reset_dut();

      // Byte fill, continuous stream
      step(1'b1, 32'h0000_A501, 32'h0, 32'd4, 1'b1, rand_beat(), 1'b1, "t1_start");
      dut_xfers = 0; busy_cycles = 0;
      step(1'b0, 32'h0000_A501, 32'h0, 32'd4, 1'b1, rand_beat(), 1'b1, "t1");
      check("t1_bytes", last_bits, {64{8'hA5}});
      repeat (4) step(1'b0, 32'h0000_A501, 32'h0, 32'd4, 1'b1, rand_beat(), 1'b1, "t1");
      check("t1_xfers", DW'(dut_xfers), DW'(4));
      check("t1_busy_cycles", DW'(busy_cycles), DW'(4));

      // Incrementing sequence wrapping through zero
      step(1'b1, 32'h3, 32'hFFFF_FFFE, 32'd2, 1'b1, rand_beat(), 1'b1, "t2_start");
      step(1'b0, 32'h3, 32'hFFFF_FFFE, 32'd2, 1'b1, rand_beat(), 1'b1, "t2");
      check("t2_b0_l0",  DW'(last_bits[31:0]),    DW'(32'hFFFF_FFFE));
      check("t2_b0_l1",  DW'(last_bits[63:32]),   DW'(32'hFFFF_FFFF));
      check("t2_b0_l2",  DW'(last_bits[95:64]),   DW'(32'h0));
      check("t2_b0_l15", DW'(last_bits[511:480]), DW'(32'hD));
      step(1'b0, 32'h3, 32'hFFFF_FFFE, 32'd2, 1'b1, rand_beat(), 1'b1, "t2");
      check("t2_b1_l0",  DW'(last_bits[31:0]),    DW'(32'hE));
      step(1'b0, 32'h3, 32'hFFFF_FFFE, 32'd2, 1'b1, rand_beat(), 1'b1, "t2_end");

      // Word pattern with output backpressure
      step(1'b1, 32'h2, 32'hDEAD_BEEF, 32'd3, 1'b1, rand_beat(), 1'b1, "t3_start");
      dut_xfers = 0;
      step(1'b0, 32'h2, 32'hDEAD_BEEF, 32'd3, 1'b1, rand_beat(), 1'b1, "t3");
      step(1'b0, 32'h2, 32'hDEAD_BEEF, 32'd3, 1'b1, rand_beat(), 1'b0, "t3_stall");
      check("t3_hold", last_bits, {16{32'hDEAD_BEEF}});
      step(1'b0, 32'h2, 32'hDEAD_BEEF, 32'd3, 1'b1, rand_beat(), 1'b0, "t3_stall");
      step(1'b0, 32'h2, 32'hDEAD_BEEF, 32'd3, 1'b1, rand_beat(), 1'b1, "t3");
      step(1'b0, 32'h2, 32'hDEAD_BEEF, 32'd3, 1'b1, rand_beat(), 1'b1, "t3");
      check("t3_xfers", DW'(dut_xfers), DW'(3));
      step(1'b0, 32'h2, 32'hDEAD_BEEF, 32'd3, 1'b1, rand_beat(), 1'b1, "t3_end");

      // Pass-through, third beat must stall afterwards
      step(1'b1, 32'h0, 32'h0, 32'd2, 1'b0, '0, 1'b1, "t4_start");
      step(1'b0, 32'h0, 32'h0, 32'd2, 1'b1, b1, 1'b1, "t4");
      check("t4_beat1", last_bits, b1);
      step(1'b0, 32'h0, 32'h0, 32'd2, 1'b1, b2, 1'b1, "t4");
      check("t4_beat2", last_bits, b2);
      step(1'b0, 32'h0, 32'h0, 32'd2, 1'b1, b3, 1'b1, "t4_stall");

      // Zero-length start, then start pulses and CSR changes mid-run
      step(1'b1, 32'h1, 32'h0, 32'd0, 1'b1, rand_beat(), 1'b1, "t5_zero");
      step(1'b0, 32'h1, 32'h0, 32'd0, 1'b1, rand_beat(), 1'b1, "t5_zero");
      step(1'b1, 32'h0000_3C01, 32'h0, 32'd3, 1'b1, rand_beat(), 1'b1, "t5_start");
      dut_xfers = 0;
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'h0000_7703, $urandom, 32'd9, 1'b1, rand_beat(), 1'b1, "t5_restart");
      check("t5_xfers", DW'(dut_xfers), DW'(3));

      // Reset in the middle of a sequence run, then fresh start at seed 0
      step(1'b1, 32'h3, 32'h100, 32'd5, 1'b1, rand_beat(), 1'b1, "t6_start");
      repeat (2) step(1'b0, 32'h3, 32'h100, 32'd5, 1'b1, rand_beat(), 1'b1, "t6");
      reset_dut();
      step(1'b1, 32'h3, 32'h0, 32'd1, 1'b1, rand_beat(), 1'b1, "t6_restart");
      step(1'b0, 32'h3, 32'h0, 32'd1, 1'b1, rand_beat(), 1'b1, "t6");
      check("t6_l0", DW'(last_bits[31:0]), DW'(32'h0));

      // Randomized runs with random handshakes, stray starts and resets
      for (int r = 0; r < 40; r++) begin
         logic [31:0] c0, c1, c2;
         int budget;
         c0 = $urandom;
         c1 = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
         c2 = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 8));
         step(1'b1, c0, c1, c2, 1'($urandom), rand_beat(), 1'($urandom), "rnd_start");
         budget = 200;
         while (m_run && budget > 0) begin
            if ($urandom_range(0, 99) == 0) begin
               reset_dut();
            end else begin
               step(1'($urandom_range(0, 7) == 0), $urandom, $urandom, $urandom,
                    1'($urandom), rand_beat(), 1'($urandom), "rnd");
            end
            budget--;
         end
         if (budget == 0) check("rnd_timeout", DW'(1), DW'(0));
         step(1'b0, c0, c1, c2, 1'b1, rand_beat(), 1'b1, "rnd_idle");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ext_pattern_fill.md
Name: ext_pattern_fill

Overview:
- Streaming data-path extension that sits between the cluster streamer read and write ports, with the same ext_* handshake and CSR interface as the existing memset extension.
- Generalises memset into a counted, multi-mode generator:
  - pass-through
  - byte fill
  - 32-bit word-pattern fill
  - incrementing 32-bit sequence
- A run is armed by ext_start_i, lasts a CSR-programmed number of beats, and reports ext_busy_o until the last beat is accepted downstream.

Parameters:
- DataWidth, 512, stream beat width in bits; must be a multiple of 32 and at least 32.
- UserCsrNum, 3, number of 32-bit user CSRs; fixed at 3, elaboration error otherwise.
- CntWidth, 32, width of the beat counter; beat count is taken from ext_csr_i_2[CntWidth-1:0].

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- ext_data_i_ready  out  1  input stream ready
- ext_data_i_valid  in  1  input stream valid
- ext_data_i_bits  in  DataWidth  input beat
- ext_data_o_ready  in  1  output stream ready
- ext_data_o_valid  out  1  output stream valid
- ext_data_o_bits  out  DataWidth  output beat
- ext_csr_i_0  in  32  [1:0] mode (0 pass, 1 byte, 2 word, 3 incr); [15:8] fill byte; other bits ignored
- ext_csr_i_1  in  32  word pattern (mode 2) or sequence seed (mode 3)
- ext_csr_i_2  in  32  beat count N
- ext_start_i  in  1  one-cycle start pulse
- ext_busy_o  out  1  high while a run is active

Behaviour:
- Reset: rst_ni low at a rising edge leads to:
  - state IDLE, beat counter 0, all latched CSR registers 0.
  - ext_busy_o=0, ext_data_o_valid=0, ext_data_i_ready=0, ext_data_o_bits=0.
  - Reset during RUN aborts the run. No further beats are emitted.
- State machine, IDLE:
  - ext_start_i=1 with csr_2!=0: latch mode, byte, pattern and N; set lane_base=csr_1; go to RUN on the next cycle.
  - ext_start_i=1 with csr_2==0: ignored; stay in IDLE, busy stays 0.
- State machine, RUN:
  - ext_busy_o=1.
  - A beat transfers when ext_data_i_valid & ext_data_o_ready.
  - On each transfer: remaining--, lane_base += Lanes (Lanes = DataWidth/32, mod 2^32).
  - Transfer with remaining==1: go to IDLE; busy drops the next cycle.
  - ext_start_i in RUN is ignored. CSR changes in RUN have no effect because only latched values are used.
- Handshake:
  - In RUN: ext_data_o_valid = ext_data_i_valid, and ext_data_i_ready = ext_data_o_ready. Both are combinational and zero-latency.
  - In IDLE: both are forced to 0, so input beats stall and nothing is emitted.
  - Exactly one input beat is consumed per output beat in every mode.
- Data (combinational from latched state):
  - mode 0: o_bits = i_bits.
  - mode 1: every byte = fill byte.
  - mode 2: every 32-bit lane = pattern.
  - mode 3: lane k = lane_base + k (mod 2^32), with lane 0 at bits [31:0].
  - ext_data_o_bits = 0 when not in RUN.
- Wrap-around:
  - The sequence wraps modulo 2^32 with no saturation.
  - The beat counter never underflows, because the exit on remaining==1 is taken before any further decrement.
- Stalls: backpressure (o_ready=0) or a missing input (i_valid=0) holds remaining, lane_base and the output value unchanged.
- Simultaneous events: a start pulse in the same cycle as the final transfer is ignored. A new run requires a start pulse while in IDLE.

Test Plan:
- Reset, then mode=1, byte=0xA5, N=4, start, with a continuous valid/ready stream: 4 beats, each all 0xA5 bytes; busy high for exactly 4 cycles; i_ready=0 afterwards.
- Mode=3, seed=0xFFFFFFFE, DataWidth=512, N=2: beat0 lanes = FFFFFFFE, FFFFFFFF, 0, 1, …, 0xD; beat1 lane0 = 0x0000000E.
- Mode=2, pattern=0xDEADBEEF, N=3, with o_ready toggled 1,0,0,1,1: output is held stable during the stalls; exactly 3 transfers; busy falls after the 3rd transfer.
- Mode=0, N=2, input beats 0x1…, 0x2…: output equals input; a third input beat stays stalled (i_ready=0) once back in IDLE.
- Start with N=0: busy stays 0. Start pulse during RUN, with CSRs changed mid-run: no effect; original N and mode complete.
- Reset asserted after 2 of 5 beats in mode 3: next cycle busy=0, valid=0; a fresh start with seed=0 restarts lane0 at 0.
